// File: rtl/scr1_dmem_ram_adapter.sv
// SCR1 32-bit data-memory port to 64-bit byte-enabled on-chip RAM.
// Four-state FSM with registered RAM strobes and core responses.
module scr1_dmem_ram_adapter #(
  parameter int ADDR_W    = 16,
  parameter int RAM_WORDS = 8192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dmem_req,
  output logic              dmem_req_ack,
  input  logic              dmem_cmd,
  input  logic [1:0]        dmem_width,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [31:0]       dmem_wdata,
  output logic [31:0]       dmem_rdata,
  output logic [1:0]        dmem_resp,
  output logic [ADDR_W-4:0] ram_address,
  output logic [7:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [63:0]       ram_writedata,
  input  logic [63:0]       ram_readdata,
  output logic              ram_clken
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } state_t;

  localparam logic [1:0] RESP_IDLE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  state_t            state_q;
  logic              cmd_q;
  logic [1:0]        width_q;
  logic [2:0]        off_q;
  logic [31:0]       rdata_q;
  logic [1:0]        resp_q;
  logic [ADDR_W-4:0] addr_q;
  logic [7:0]        be_q;
  logic              cs_q;
  logic              we_q;
  logic [63:0]       wd_q;
  logic              clken_q;

  logic              illegal_d;
  logic [7:0]        be_d;
  logic [63:0]       wd_d;
  logic [31:0]       lane_d;
  logic [31:0]       idx_d;
  logic [31:0]       shifted_d;

  // Request legality, lane mask and replicated write data from the core bus
  always_comb begin
    illegal_d = 1'b0;
    be_d      = 8'h00;
    wd_d      = 64'h0;
    idx_d     = 32'(dmem_addr[ADDR_W-1:3]);
    case (dmem_width)
      2'b00: begin
        be_d = 8'h01 << dmem_addr[2:0];
        wd_d = {8{dmem_wdata[7:0]}};
      end
      2'b01: begin
        illegal_d = dmem_addr[0];
        be_d      = 8'h03 << dmem_addr[2:0];
        wd_d      = {4{dmem_wdata[15:0]}};
      end
      2'b10: begin
        illegal_d = |dmem_addr[1:0];
        be_d      = 8'h0F << dmem_addr[2:0];
        wd_d      = {2{dmem_wdata}};
      end
      default: illegal_d = 1'b1;
    endcase
    if (idx_d >= 32'(RAM_WORDS))
      illegal_d = 1'b1;
  end

  // Read lane extraction, zero-extended to 32 bits
  always_comb begin
    shifted_d = 32'(ram_readdata >> {off_q, 3'b000});
    lane_d    = shifted_d;
    case (width_q)
      2'b00:   lane_d = {24'h0, shifted_d[7:0]};
      2'b01:   lane_d = {16'h0, shifted_d[15:0]};
      default: lane_d = shifted_d;
    endcase
  end

  // Transaction FSM; every RAM strobe and core response is a flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= 1'b0;
      width_q <= 2'b00;
      off_q   <= 3'b000;
      rdata_q <= 32'h0;
      resp_q  <= RESP_IDLE;
      addr_q  <= '0;
      be_q    <= 8'h00;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      wd_q    <= 64'h0;
      clken_q <= 1'b0;
    end else begin
      clken_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          resp_q <= RESP_IDLE;
          if (dmem_req && clken_q) begin
            cmd_q   <= dmem_cmd;
            width_q <= dmem_width;
            off_q   <= dmem_addr[2:0];
            rdata_q <= 32'h0;
            if (illegal_d) begin
              resp_q  <= RESP_ERR;
              state_q <= RESP;
            end else begin
              cs_q    <= 1'b1;
              we_q    <= dmem_cmd;
              addr_q  <= dmem_addr[ADDR_W-1:3];
              be_q    <= be_d;
              wd_q    <= wd_d;
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          cs_q <= 1'b0;
          we_q <= 1'b0;
          be_q <= 8'h00;
          if (cmd_q) begin
            resp_q  <= RESP_OK;
            state_q <= RESP;
          end else begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          rdata_q <= lane_d;
          resp_q  <= RESP_OK;
          state_q <= RESP;
        end
        RESP: begin
          resp_q  <= RESP_IDLE;
          rdata_q <= 32'h0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req_ack   = (state_q == IDLE) && clken_q;
  assign dmem_rdata     = rdata_q;
  assign dmem_resp      = resp_q;
  assign ram_address    = addr_q;
  assign ram_byteenable = be_q;
  assign ram_chipselect = cs_q;
  assign ram_write      = we_q;
  assign ram_writedata  = wd_q;
  assign ram_clken      = clken_q;

endmodule

// File: doc/scr1_dmem_ram_adapter.md
Name: scr1_dmem_ram_adapter

Overview:
- Sits directly upstream of the 64-bit single-port on-chip RAM slave (8192 x 64, byte-enabled, unregistered read output, one-cycle read latency).
- Converts the SCR1 core's 32-bit data-memory request/response interface into 64-bit RAM accesses.
- Handles lane selection, byte-enable generation, write-data replication and read-data extraction.
- Flags misaligned or illegal-width requests as errors without touching the RAM.

Parameters:
- ADDR_W, 16: core byte-address width; RAM word address is ADDR_W-3 bits (13).
- RAM_WORDS, 8192: RAM depth; any word index >= RAM_WORDS returns an error.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high reset.
- dmem_req  in  1  core request valid.
- dmem_req_ack  out  1  request accepted this cycle (high only in IDLE).
- dmem_cmd  in  1  0 = read, 1 = write.
- dmem_width  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- dmem_addr  in  ADDR_W  byte address.
- dmem_wdata  in  32  write data, right-aligned.
- dmem_rdata  out  32  read data, right-aligned, zero-extended; valid while dmem_resp = 01.
- dmem_resp  out  2  00 = idle, 01 = ok, 10 = error; asserted for one cycle.
- ram_address  out  ADDR_W-3  RAM word address.
- ram_byteenable  out  8  RAM byte lanes.
- ram_chipselect  out  1  RAM select.
- ram_write  out  1  RAM write strobe.
- ram_writedata  out  64  RAM write data.
- ram_readdata  in  64  RAM read data, valid the cycle after the address is presented.
- ram_clken  out  1  RAM clock enable.

Behaviour:
- Reset (asynchronous): state = IDLE; dmem_resp = 00; dmem_rdata = 0; ram_chipselect = 0; ram_write = 0; ram_address = 0; ram_byteenable = 0; ram_writedata = 0; ram_clken = 0.
  - ram_clken goes to 1 on the first clock after reset deasserts and stays 1.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - dmem_req_ack = 1.
  - On dmem_req, capture cmd, width, addr and wdata into registers.
  - If the request is illegal, go to RESP with error. Illegal means any of:
    - width = 11;
    - half with addr[0] != 0;
    - word with addr[1:0] != 0;
    - word index addr[ADDR_W-1:3] >= RAM_WORDS.
  - Otherwise go to ACCESS.
- ACCESS (exactly one cycle): all ram_* outputs come from registers.
  - ram_chipselect = 1; ram_address = addr[ADDR_W-1:3]; ram_write = cmd.
  - ram_byteenable = mask << addr[2:0], where mask = 0x01 (byte), 0x03 (half), 0x0F (word).
  - ram_writedata replicates wdata: byte to 8 copies of [7:0], half to 4 copies of [15:0], word to {wdata, wdata}.
  - Next state: write goes to RESP; read goes to CAPTURE.
- CAPTURE (reads only): ram_chipselect = 0.
  - Register the lane from ram_readdata at bit offset 8*addr[2:0], width 8/16/32, zero-extended into dmem_rdata.
  - Go to RESP.
- RESP: dmem_resp = 01 (ok) or 10 (error) for exactly one cycle, then IDLE.
  - dmem_rdata holds the captured value for reads; it is 0 for errors and writes.
- Outside ACCESS: ram_chipselect = 0, ram_write = 0, ram_byteenable = 0.
- Latency from accept edge to dmem_resp:
  - write: 2 cycles;
  - read: 3 cycles;
  - error: 1 cycle.
- Back-to-back: a new request can be accepted in the cycle after RESP. Throughput is one read per 4 cycles and one write per 3 cycles.
- dmem_req is ignored outside IDLE; the core holds the request until dmem_req_ack.
- If reset asserts mid-transaction, an in-flight RAM write is aborted: ram_write drops asynchronously and no response is issued.

Test Plan:
- Reset with dmem_req high -> all outputs at reset values; req_ack = 1 and ram_clken = 1 one cycle after reset release.
- Word write addr 0x0104, wdata 0xDEADBEEF -> in ACCESS: ram_address = 0x020, byteenable = 0xF0, writedata = 0xDEADBEEF_DEADBEEF, write = 1; resp = 01 two cycles after accept.
- Byte read addr 0x0107 with RAM word 0x1122334455667788 -> byteenable = 0x80, write = 0; rdata = 0x00000011 with resp = 01 three cycles after accept.
- Half write addr 0x0003 -> resp = 10 one cycle after accept; ram_chipselect never asserted.
- Width = 11, or word addr 0xFFFC with RAM_WORDS = 4096 -> resp = 10, no RAM access.
- Write then read of the same half-word addr 0x0202, data 0xA5C3, held requests -> second req_ack exactly one cycle after the first resp; read returns 0x0000A5C3.
